// File: rtl/pipe_dff_array.sv
// pipe_dff_array: PIPE_DEPTH-stage delay line for a 2-D array of WIDTH-bit elements.
// Define PIPE_DFF_XCHECK_EN to add simulation-only X/Z checks on en and in.
module pipe_dff_array #(
    parameter int WIDTH         = 16,
    parameter int ARRAY_SIZE1   = 1,
    parameter int ARRAY_SIZE2   = 1,
    parameter int PIPE_DEPTH    = 1,
    parameter int RETIME_STATUS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in  [ARRAY_SIZE1][ARRAY_SIZE2],
    output logic [WIDTH-1:0] out [ARRAY_SIZE1][ARRAY_SIZE2]
);

    // RETIME_STATUS only steers the synthesis attribute below.
    logic unused_cfg;
    assign unused_cfg = (RETIME_STATUS != 0);

    generate
        if (PIPE_DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, en};
            assign out = in;
        end else begin : g_pipe
            (* retime = RETIME_STATUS *)
            logic [WIDTH-1:0] stage [PIPE_DEPTH][ARRAY_SIZE1][ARRAY_SIZE2];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < PIPE_DEPTH; k++) begin
                        for (int i = 0; i < ARRAY_SIZE1; i++) begin
                            for (int j = 0; j < ARRAY_SIZE2; j++) begin
                                stage[k][i][j] <= '0;
                            end
                        end
                    end
                end else if (en) begin
                    stage[0] <= in;
                    for (int k = 1; k < PIPE_DEPTH; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign out = stage[PIPE_DEPTH-1];
        end
    endgenerate

`ifdef PIPE_DFF_XCHECK_EN
    generate
        if (PIPE_DEPTH < 0) begin : g_bad_depth
            $error("pipe_dff_array: PIPE_DEPTH must be >= 0, got %0d", PIPE_DEPTH);
        end
    endgenerate

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            assert (!$isunknown(en))
                else $error("pipe_dff_array: en is X/Z at rising clk");
            if (en === 1'b1) begin
                for (int i = 0; i < ARRAY_SIZE1; i++) begin
                    for (int j = 0; j < ARRAY_SIZE2; j++) begin
                        if ($isunknown(in[i][j]))
                            $error("pipe_dff_array: X/Z on in[%0d][%0d]", i, j);
                    end
                end
            end
        end
    end
`else
    // Synthesis builds carry no checking logic.
`endif

endmodule

// File: tb/tb_pipe_dff_array.sv
// Bench for pipe_dff_array: scalar depth-3 stream, hold and async reset, depth-0 bypass,
// and 3x3 depth-3 vs depth-2 instances sharing one source.
module tb_pipe_dff_array;

    typedef struct {
        logic [31:0] din;
        logic        en;
        logic [31:0] exp;
    } scalar_vec_t;

    typedef struct {
        logic [31:0] din;
        logic        rst;
        logic        en;
    } bypass_vec_t;

    // code: 0 = all zero, 1 = pattern A, 2 = pattern B
    typedef struct {
        bit load_b;
        int code2;
        int code3;
        bit differ;
    } array_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] d3_in  [1][1];
    logic [31:0] d3_out [1][1];
    logic [31:0] d0_in  [1][1];
    logic [31:0] d0_out [1][1];
    logic [23:0] src    [3][3];
    logic [23:0] a3_out [3][3];
    logic [23:0] a2_out [3][3];

    logic [23:0] pat_a [3][3] = '{'{24'h000001, 24'h000102, 24'h000203},
                                  '{24'h7FFFFF, 24'h800000, 24'h123456},
                                  '{24'hABCDEF, 24'hFFFC00, 24'h0F0F0F}};
    logic [23:0] pat_b [3][3] = '{'{24'h111111, 24'h222222, 24'h333333},
                                  '{24'h444444, 24'h555555, 24'h666666},
                                  '{24'h777777, 24'h888888, 24'h999999}};

    int errors = 0;
    int checks = 0;

    pipe_dff_array #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(3), .RETIME_STATUS(0))
        u_d3 (.clk(clk), .reset(reset), .en(en), .in(d3_in), .out(d3_out));

    pipe_dff_array #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(0), .RETIME_STATUS(0))
        u_d0 (.clk(clk), .reset(reset), .en(en), .in(d0_in), .out(d0_out));

    pipe_dff_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(1))
        u_a3 (.clk(clk), .reset(reset), .en(en), .in(src), .out(a3_out));

    pipe_dff_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(2), .RETIME_STATUS(0))
        u_a2 (.clk(clk), .reset(reset), .en(en), .in(src), .out(a2_out));

    always #5 clk = ~clk;

    function automatic logic [23:0] pattern(input int code, input int i, input int j);
        if (code == 1) return pat_a[i][j];
        if (code == 2) return pat_b[i][j];
        return 24'h000000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive the scalar input and enable, then sample 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [31:0] din, input logic enable);
        d3_in[0][0] = din;
        en = enable;
        @(posedge clk);
        #1;
    endtask

    scalar_vec_t svec [11];
    bypass_vec_t bvec [5];
    array_vec_t  avec [8];

    initial begin
        svec = '{'{32'd1,  1'b1, 32'd0}, '{32'd2,  1'b1, 32'd0}, '{32'd3,  1'b1, 32'd1},
                 '{32'd4,  1'b1, 32'd2}, '{32'd5,  1'b1, 32'd3}, '{32'd99, 1'b0, 32'd3},
                 '{32'd98, 1'b0, 32'd3}, '{32'd6,  1'b1, 32'd4}, '{32'd7,  1'b1, 32'd5},
                 '{32'd8,  1'b1, 32'd6}, '{32'd9,  1'b1, 32'd7}};
        bvec = '{'{32'h00000000, 1'b0, 1'b1}, '{32'hDEADBEEF, 1'b1, 1'b0},
                 '{32'h12345678, 1'b1, 1'b1}, '{32'hFFFFFFFF, 1'b0, 1'b0},
                 '{32'h80000001, 1'b0, 1'b1}};
        avec = '{'{1'b0, 0, 0, 1'b0}, '{1'b0, 1, 0, 1'b1}, '{1'b0, 1, 1, 1'b0},
                 '{1'b0, 1, 1, 1'b0}, '{1'b1, 1, 1, 1'b0}, '{1'b1, 2, 1, 1'b1},
                 '{1'b1, 2, 2, 1'b0}, '{1'b1, 2, 2, 1'b0}};

        reset = 1'b1;
        en = 1'b0;
        d3_in[0][0] = '0;
        d0_in[0][0] = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                src[i][j] = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset d3_out", d3_out[0][0], 32'd0);
        checkOutput("reset a3_out[2][1]", {8'h00, a3_out[2][1]}, 32'd0);
        checkOutput("reset a2_out[0][0]", {8'h00, a2_out[0][0]}, 32'd0);
        reset = 1'b0;

        // Depth-3 stream with a two-cycle hold after 5 is captured.
        for (int n = 0; n < 11; n++) begin
            applyStimulus(svec[n].din, svec[n].en);
            checkOutput($sformatf("stream step %0d", n), d3_out[0][0], svec[n].exp);
        end

        // Async reset between edges with the pipe full (out = 7).
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset clears out", d3_out[0][0], 32'd0);
        applyStimulus(32'd50, 1'b1);
        checkOutput("reset overrides en", d3_out[0][0], 32'd0);
        #2 reset = 1'b0;
        applyStimulus(32'd21, 1'b1);
        checkOutput("post-reset cycle 1", d3_out[0][0], 32'd0);
        applyStimulus(32'd22, 1'b1);
        checkOutput("post-reset cycle 2", d3_out[0][0], 32'd0);
        applyStimulus(32'd23, 1'b1);
        checkOutput("post-reset cycle 3", d3_out[0][0], 32'd21);
        applyStimulus(32'd24, 1'b1);
        checkOutput("post-reset cycle 4", d3_out[0][0], 32'd22);

        // Depth 0 ignores reset and en.
        for (int n = 0; n < 5; n++) begin
            d0_in[0][0] = bvec[n].din;
            reset = bvec[n].rst;
            en = bvec[n].en;
            #3;
            checkOutput($sformatf("bypass step %0d", n), d0_out[0][0], bvec[n].din);
        end
        reset = 1'b1;
        #2 reset = 1'b0;

        // 3x3 arrays: depth-2 leads depth-3 by exactly one cycle on a source change.
        for (int n = 0; n < 8; n++) begin
            bit differs;
            src = avec[n].load_b ? pat_b : pat_a;
            en = 1'b1;
            @(posedge clk);
            #1;
            differs = 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    checkOutput($sformatf("a2[%0d][%0d] step %0d", i, j, n),
                                {8'h00, a2_out[i][j]}, {8'h00, pattern(avec[n].code2, i, j)});
                    checkOutput($sformatf("a3[%0d][%0d] step %0d", i, j, n),
                                {8'h00, a3_out[i][j]}, {8'h00, pattern(avec[n].code3, i, j)});
                    if (a2_out[i][j] !== a3_out[i][j]) differs = 1'b1;
                end
            end
            checkOutput($sformatf("depth2 vs depth3 differ step %0d", n),
                        {31'd0, differs}, {31'd0, avec[n].differ});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_dff_array.md
Name: pipe_dff_array

Overview:
- Generic parameterised pipeline/delay register used to align signals across pipeline stages in the rasterizer datapath and its verification benches.
- Carries a two-dimensional array of WIDTH-bit elements through PIPE_DEPTH register stages, with a common enable and reset.
- Scalar use: ARRAY_SIZE1 = ARRAY_SIZE2 = 1. One-dimensional use: ARRAY_SIZE2 = 1. This replaces separate scalar, 1-D and 2-D delay-line flavours.

Parameters:
- WIDTH, 16: bits per element.
- ARRAY_SIZE1, 1: outer array dimension, e.g. vertices.
- ARRAY_SIZE2, 1: inner array dimension, e.g. axes.
- PIPE_DEPTH, 1: number of register stages, >= 0. 0 means combinational pass-through.
- RETIME_STATUS, 0: 1 marks the stages as retimeable for synthesis (attribute only). It has no functional effect.

Ports:
- clk, input, 1: clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: stage enable. 1 = advance the pipeline, 0 = all stages hold.
- in, input, [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0] x WIDTH (unpacked array of WIDTH-bit vectors): data entering stage 0.
- out, output, same shape as in: data leaving the final stage.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset: while reset=1, every stage register of every element is cleared to 0 immediately, without waiting for a clock edge. out = 0 for PIPE_DEPTH >= 1.
- Shift rule: on each rising clk with reset=0 and en=1:
  - stage[0] <= in
  - stage[k] <= stage[k-1] for k = 1..PIPE_DEPTH-1
  - out = stage[PIPE_DEPTH-1]
- Latency: with en held at 1, out equals in from exactly PIPE_DEPTH cycles earlier.
- Hold: en=0 freezes all stages simultaneously. No bubble is inserted and no data is lost.
- PIPE_DEPTH = 0: out = in combinationally. clk, en and reset are ignored.
- Element independence: elements are fully independent, with no packing or reordering across the array. Data is treated as raw bits; signed values keep their bit pattern.
- Reset during operation: reset asserted between clock edges clears every stage at once. After reset deasserts, out reads 0 for PIPE_DEPTH cycles, then the valid delayed input appears.
- Reset and enable together: reset overrides en and the clock edge.
- Equal-depth instances: two instances with identical parameters and inputs produce bit-identical outputs. Instances of depth N and N-1 fed from the same source give consecutive-sample values, which is used for change detection.
- RETIME_STATUS=1: emits a synthesis retiming attribute on the stage registers. Simulation behaviour is identical to 0.

Optional Feature:
- Macro: PIPE_DFF_XCHECK_EN.
- When defined, simulation-only assertions are included:
  - PIPE_DEPTH >= 0, checked at elaboration.
  - en is never X/Z on a rising clk while reset=0.
  - Any X/Z bit in `in` sampled with en=1 raises $error naming the element indices.
- When undefined, no checking logic is present and the RTL is purely synthesisable.
- Datapath behaviour is identical in both cases.

Test Plan:
- Depth 3, 1x1, WIDTH=32. After reset, drive in = 1,2,3,4,... each cycle with en=1 -> out = 0,0,0, then 1,2,3,... Exactly 3-cycle latency.
- Depth 3, en dropped to 0 for 2 cycles after in = 5 is captured -> out holds its current value for 2 cycles, then resumes the sequence with no sample skipped or duplicated.
- Reset asserted mid-stream, between clock edges, with the pipeline full (out = 7) -> out = 0 immediately without a clock edge. After release, out = 0 for 3 cycles, then new data appears.
- Depth 0, 1x1 -> out follows in combinationally. Toggling reset and en has no effect.
- Depth 3, 3x3, WIDTH=24. Load a distinct value per element, including negative 24'hFFFC00 at [2][1] -> each out[i][j] equals the matching in[i][j] 3 cycles later, bit-exact, with no cross-element mixing.
- Depth 3 and depth 2 instances on the same 3x3 source. Change the source value once -> the outputs differ for exactly 1 cycle (depth-2 updates first), then match.
